dma_page_addr_latch: RTL and testbench

//  Downstream address stage of the 8237 DMA controller. Captures the high address byte the

---
 rtl/dma_page_addr_latch_if.sv | 36 +++
 rtl/dma_page_addr_latch.sv | 159 +++++++++++++++
 tb/tb_dma_page_addr_latch.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/dma_page_addr_latch_if.sv
// Bus bundle between the 8237 / CPU side and the DMA page address latch.
// The master modport drives the controller and CPU strobes. The slave
// modport belongs to the address stage.
interface dma_page_addr_latch_if #(
  parameter int PAGE_W = 4
);
  // 8237 side
  logic                aen;
  logic                adstb;
  logic [3:0]          dack;
  logic [7:0]          db;
  logic [7:0]          a_lo;
  // CPU side
  logic                cs_page;
  logic                ior_n;
  logic                iow_n;
  logic [3:0]          addr;
  logic [7:0]          cpu_din;
  logic [7:0]          cpu_dout;
  logic                cpu_dout_en;
  // System address side
  logic [PAGE_W+15:0]  dma_addr;
  logic                dma_addr_en;
  logic [1:0]          active_ch;
  logic                err_nolatch;

  modport master (
    output aen, adstb, dack, db, a_lo, cs_page, ior_n, iow_n, addr, cpu_din,
    input  cpu_dout, cpu_dout_en, dma_addr, dma_addr_en, active_ch, err_nolatch
  );

  modport slave (
    input  aen, adstb, dack, db, a_lo, cs_page, ior_n, iow_n, addr, cpu_din,
    output cpu_dout, cpu_dout_en, dma_addr, dma_addr_en, active_ch, err_nolatch
  );
endinterface

// File: rtl/dma_page_addr_latch.sv
// Downstream address stage of an 8237 DMA controller. It latches A15..A8
// from the data bus on ADSTB and holds the CPU-programmable per-channel page
// registers. During transfers it merges page, high byte and A7..A0 into the
// registered system address.
module dma_page_addr_latch #(
  parameter int         PAGE_W  = 4,
  parameter logic [3:0] CH0_OFF = 4'd7,
  parameter logic [3:0] CH1_OFF = 4'd3,
  parameter logic [3:0] CH2_OFF = 4'd1,
  parameter logic [3:0] CH3_OFF = 4'd2
) (
  input  logic                  clk,
  input  logic                  reset,
  dma_page_addr_latch_if.slave  bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_LATCHED = 2'd2;
  localparam logic [1:0] ST_XFER    = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [PAGE_W-1:0]  page_q [4];
  logic [7:0]         hi_latch_q;
  logic               iow_n_q;
  logic [7:0]         cpu_dout_q;
  logic               cpu_dout_en_q;
  logic [PAGE_W+15:0] dma_addr_q;
  logic               dma_addr_en_q;
  logic [1:0]         active_ch_q;
  logic               err_q;

  logic               off_hit;
  logic [1:0]         off_ch;
  logic               dack_any;
  logic [1:0]         dack_ch;
  logic               wr_fire;
  logic               rd_sel;
  logic [7:0]         hi_d;
  logic               set_err;
  logic               load_ch;

  // Decode the CPU port offset into a page register index.
  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    off_hit = 1'b1;
    off_ch  = 2'd0;
    if      (bus.addr == CH0_OFF) off_ch = 2'd0;
    else if (bus.addr == CH1_OFF) off_ch = 2'd1;
    else if (bus.addr == CH2_OFF) off_ch = 2'd2;
    else if (bus.addr == CH3_OFF) off_ch = 2'd3;
    else                          off_hit = 1'b0;
  end

  // The lowest-numbered asserted DACK (active-low) owns the transfer.
  always_comb begin
    dack_any = ~&bus.dack;
    if      (!bus.dack[0]) dack_ch = 2'd0;
    else if (!bus.dack[1]) dack_ch = 2'd1;
    else if (!bus.dack[2]) dack_ch = 2'd2;
    else                   dack_ch = 2'd3;
  end

  // A write fires once on the falling edge of iow_n, and only while the CPU
  // owns the bus. A strobe that begins under AEN is lost, not deferred.
  assign wr_fire = !bus.cs_page && !bus.iow_n && iow_n_q && !bus.aen;
  assign rd_sel  = !bus.cs_page && !bus.ior_n && !bus.aen;
  // A re-strobe in the same clock reaches dma_addr without waiting for the latch.
  assign hi_d    = bus.adstb ? bus.db : hi_latch_q;

  // Cycle-phase next state. A low AEN overrides everything, including a DACK.
  always_comb begin
    state_d = state_q;
    set_err = 1'b0;
    load_ch = 1'b0;
    if (!bus.aen) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    state_d = ST_ARMED;
        ST_ARMED: begin
          if (bus.adstb) begin
            state_d = ST_LATCHED;
          end else if (dack_any) begin
            state_d = ST_XFER;
            set_err = 1'b1;
            load_ch = 1'b1;
          end
        end
        ST_LATCHED: begin
          if (dack_any) begin
            state_d = ST_XFER;
            load_ch = 1'b1;
          end
        end
        ST_XFER:    if (!dack_any) state_d = ST_LATCHED;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Page registers, high-byte latch and the iow_n edge detector.
  // NOTE: the page file is only four entries and must read back 0 after reset,
  // so it is reset like ordinary flops rather than treated as a RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) page_q[i] <= '0;
      hi_latch_q <= 8'h00;
      iow_n_q    <= 1'b1;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values, whatever the statement order.
      iow_n_q <= bus.iow_n;
      if (bus.adstb) hi_latch_q <= bus.db;
      if (wr_fire && off_hit) page_q[off_ch] <= bus.cpu_din[PAGE_W-1:0];
    end
  end

  // Registered CPU read-back with one clock of latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_dout_q    <= 8'h00;
      cpu_dout_en_q <= 1'b0;
    end else begin
      cpu_dout_en_q <= rd_sel;
      cpu_dout_q    <= off_hit ? 8'({page_q[off_ch]}) : 8'h00;
    end
  end

  // Cycle phase, system address output and the sticky missing-ADSTB flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      dma_addr_q    <= '0;
      dma_addr_en_q <= 1'b0;
      active_ch_q   <= 2'd0;
      err_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_ch) active_ch_q <= dack_ch;
      if (bus.aen && state_q == ST_XFER && dack_any) begin
        dma_addr_en_q <= 1'b1;
        dma_addr_q    <= {page_q[active_ch_q], hi_d, bus.a_lo};
      end else begin
        dma_addr_en_q <= 1'b0;
      end
      // Setting needs AEN high and clearing needs it low, so the two never collide.
      if (set_err)                          err_q <= 1'b1;
      else if (wr_fire && bus.addr == 4'hF) err_q <= 1'b0;
    end
  end

  assign bus.cpu_dout    = cpu_dout_q;
  assign bus.cpu_dout_en = cpu_dout_en_q;
  assign bus.dma_addr    = dma_addr_q;
  assign bus.dma_addr_en = dma_addr_en_q;
  assign bus.active_ch   = active_ch_q;
  assign bus.err_nolatch = err_q;

endmodule

// File: tb/tb_dma_page_addr_latch.sv
// Self-checking bench for dma_page_addr_latch. Expected read data and DMA
// addresses are queued when the stimulus is applied. They are popped and
// compared when the DUT presents its registered output.
module tb_dma_page_addr_latch;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] sb [$];
  logic [31:0] exp;

  dma_page_addr_latch_if #(.PAGE_W(4)) bus ();

  dma_page_addr_latch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle 1 time unit past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [3:0] off, input logic [7:0] din);
    bus.cs_page = 1'b0; bus.addr = off; bus.cpu_din = din; bus.iow_n = 1'b0;
    tick();
    bus.iow_n = 1'b1; bus.cs_page = 1'b1;
    tick();
  endtask

  // Pop the next expected value from the scoreboard, or X if nothing was queued.
  task automatic sb_pop(output logic [31:0] v);
    v = (sb.size() != 0) ? sb.pop_front() : 'x;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.aen = 0; bus.adstb = 0; bus.dack = 4'hF; bus.db = 0; bus.a_lo = 0;
    bus.cs_page = 1; bus.ior_n = 1; bus.iow_n = 1; bus.addr = 0; bus.cpu_din = 0;
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++; if (bus.dma_addr_en !== 1'b0) begin errors++; $display("FAIL reset_dma_addr_en got=%b exp=0", bus.dma_addr_en); end
    checks++; if (bus.dma_addr !== 20'h0) begin errors++; $display("FAIL reset_dma_addr got=%h exp=00000", bus.dma_addr); end
    checks++; if (bus.active_ch !== 2'd0) begin errors++; $display("FAIL reset_active_ch got=%0d exp=0", bus.active_ch); end
    checks++; if (bus.err_nolatch !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bus.err_nolatch); end
    checks++; if (bus.cpu_dout_en !== 1'b0) begin errors++; $display("FAIL reset_dout_en got=%b exp=0", bus.cpu_dout_en); end
  endtask

  task automatic test_cpu_rw();
    logic [3:0] offs [7] = '{4'h3, 4'h4, 4'h7, 4'h1, 4'h2, 4'h0, 4'hF};
    logic [7:0] exps [7] = '{8'h0A, 8'h00, 8'h05, 8'h0C, 8'h03, 8'h00, 8'h00};
    cpu_write(4'h3, 8'h0A);
    cpu_write(4'h1, 8'h0C);
    cpu_write(4'h2, 8'h33);
    cpu_write(4'h4, 8'h0F);
    // Held strobe: only the first clock of iow_n low may commit.
    bus.cs_page = 0; bus.addr = 4'h7; bus.cpu_din = 8'hF5; bus.iow_n = 0;
    tick();
    bus.cpu_din = 8'h09;
    tick(); tick();
    bus.iow_n = 1; bus.cs_page = 1;
    tick();
    bus.cs_page = 0; bus.ior_n = 0;
    for (int i = 0; i < 7; i++) begin
      bus.addr = offs[i];
      sb.push_back({24'h0, exps[i]});
      tick();
      sb_pop(exp);
      checks++; if (bus.cpu_dout_en !== 1'b1) begin errors++; $display("FAIL rd_en_%0h got=%b exp=1", offs[i], bus.cpu_dout_en); end
      checks++; if (bus.cpu_dout !== exp[7:0]) begin errors++; $display("FAIL rd_data_%0h got=%h exp=%h", offs[i], bus.cpu_dout, exp[7:0]); end
    end
    bus.ior_n = 1; bus.cs_page = 1;
    tick();
    checks++; if (bus.cpu_dout_en !== 1'b0) begin errors++; $display("FAIL rd_en_release got=%b exp=0", bus.cpu_dout_en); end
  endtask

  task automatic test_dma_xfer();
    bit seen;
    bus.aen = 1; tick();
    bus.adstb = 1; bus.db = 8'h12; tick();
    bus.adstb = 0; bus.db = 8'hEE; bus.dack = 4'b1101; bus.a_lo = 8'h34;
    sb.push_back(32'hA1234);
    seen = 0;
    for (int c = 0; c < 6 && !seen; c++) begin
      tick();
      seen = bus.dma_addr_en;
    end
    checks++; if (!seen) begin errors++; $display("FAIL xfer_timeout got=no dma_addr_en exp=dma_addr_en within 6 clk"); end
    sb_pop(exp);
    checks++; if (bus.dma_addr !== exp[19:0]) begin errors++; $display("FAIL xfer_addr got=%h exp=%h", bus.dma_addr, exp[19:0]); end
    checks++; if (bus.active_ch !== 2'd1) begin errors++; $display("FAIL xfer_ch got=%0d exp=1", bus.active_ch); end
    bus.a_lo = 8'h35; sb.push_back(32'hA1235); tick(); sb_pop(exp);
    checks++; if (bus.dma_addr !== exp[19:0]) begin errors++; $display("FAIL xfer_refresh got=%h exp=%h", bus.dma_addr, exp[19:0]); end
    bus.dack = 4'hF; tick();
    checks++; if (bus.dma_addr_en !== 1'b0) begin errors++; $display("FAIL xfer_dack_release got=%b exp=0", bus.dma_addr_en); end
    // Next byte in the block: high byte retained, new channel 0.
    bus.dack = 4'b1110; bus.a_lo = 8'h00; sb.push_back(32'h51200); tick(); tick(); sb_pop(exp);
    checks++; if (bus.dma_addr_en !== 1'b1 || bus.dma_addr !== exp[19:0]) begin errors++; $display("FAIL xfer_next_byte got=%b/%h exp=1/%h", bus.dma_addr_en, bus.dma_addr, exp[19:0]); end
    checks++; if (bus.active_ch !== 2'd0) begin errors++; $display("FAIL xfer_next_ch got=%0d exp=0", bus.active_ch); end
    // Re-strobe during XFER is visible with one clock latency.
    bus.adstb = 1; bus.db = 8'h56; bus.a_lo = 8'h78; sb.push_back(32'h55678); tick(); sb_pop(exp);
    checks++; if (bus.dma_addr !== exp[19:0]) begin errors++; $display("FAIL xfer_restrobe got=%h exp=%h", bus.dma_addr, exp[19:0]); end
    bus.adstb = 0; bus.db = 8'h00; bus.a_lo = 8'h79; sb.push_back(32'h55679); tick(); sb_pop(exp);
    checks++; if (bus.dma_addr !== exp[19:0]) begin errors++; $display("FAIL xfer_hold_hi got=%h exp=%h", bus.dma_addr, exp[19:0]); end
    bus.aen = 0; bus.dack = 4'hF; tick();
    checks++; if (bus.dma_addr_en !== 1'b0 || bus.err_nolatch !== 1'b0) begin errors++; $display("FAIL xfer_end got=%b/%b exp=0/0", bus.dma_addr_en, bus.err_nolatch); end
  endtask

  task automatic test_nolatch_err();
    bus.aen = 1; tick();
    bus.dack = 4'b1011; bus.a_lo = 8'h01; sb.push_back(32'hC5601); tick();
    checks++; if (bus.err_nolatch !== 1'b1) begin errors++; $display("FAIL err_set got=%b exp=1", bus.err_nolatch); end
    tick(); sb_pop(exp);
    checks++; if (bus.dma_addr_en !== 1'b1 || bus.dma_addr !== exp[19:0]) begin errors++; $display("FAIL err_stale_addr got=%b/%h exp=1/%h", bus.dma_addr_en, bus.dma_addr, exp[19:0]); end
    checks++; if (bus.active_ch !== 2'd2) begin errors++; $display("FAIL err_ch got=%0d exp=2", bus.active_ch); end
    bus.aen = 0; bus.dack = 4'hF; tick();
    checks++; if (bus.err_nolatch !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", bus.err_nolatch); end
    cpu_write(4'hF, 8'h00);
    checks++; if (bus.err_nolatch !== 1'b0) begin errors++; $display("FAIL err_clear got=%b exp=0", bus.err_nolatch); end
  endtask

  task automatic test_aen_blocks_write();
    bus.aen = 1; bus.cs_page = 0; bus.addr = 4'h7; bus.cpu_din = 8'h0E; bus.iow_n = 0; bus.ior_n = 0;
    tick(); tick();
    checks++; if (bus.cpu_dout_en !== 1'b0) begin errors++; $display("FAIL aen_read_blocked got=%b exp=0", bus.cpu_dout_en); end
    bus.ior_n = 1; bus.aen = 0;
    tick(); tick();
    bus.iow_n = 1; tick();
    bus.ior_n = 0; sb.push_back(32'h05); tick(); sb_pop(exp);
    checks++; if (bus.cpu_dout !== exp[7:0]) begin errors++; $display("FAIL aen_write_dropped got=%h exp=%h", bus.cpu_dout, exp[7:0]); end
    bus.ior_n = 1; bus.cs_page = 1; tick();
  endtask

  task automatic test_back_to_back();
    bus.aen = 1; tick();
    bus.adstb = 1; bus.db = 8'h77; tick();
    bus.adstb = 0; bus.dack = 4'b0101; bus.a_lo = 8'h10; sb.push_back(32'hA7710); tick();
    checks++; if (bus.active_ch !== 2'd1 || bus.err_nolatch !== 1'b0) begin errors++; $display("FAIL multi_dack got=%0d/%b exp=1/0", bus.active_ch, bus.err_nolatch); end
    tick(); sb_pop(exp);
    checks++; if (bus.dma_addr !== exp[19:0]) begin errors++; $display("FAIL multi_addr got=%h exp=%h", bus.dma_addr, exp[19:0]); end
    bus.dack = 4'hF; tick();
    bus.dack = 4'b0111; bus.aen = 0; tick();
    checks++; if (bus.dma_addr_en !== 1'b0 || bus.active_ch !== 2'd1) begin errors++; $display("FAIL aen_wins got=%b/%0d exp=0/1", bus.dma_addr_en, bus.active_ch); end
    bus.dack = 4'hF; tick();
  endtask

  task automatic test_reset_mid_xfer();
    bus.aen = 1; tick();
    bus.dack = 4'b1110; tick(); tick();
    checks++; if (bus.dma_addr_en !== 1'b1 || bus.err_nolatch !== 1'b1) begin errors++; $display("FAIL pre_reset got=%b/%b exp=1/1", bus.dma_addr_en, bus.err_nolatch); end
    #3 reset = 1'b1;
    #1;
    checks++; if (bus.dma_addr_en !== 1'b0 || bus.dma_addr !== 20'h0 || bus.err_nolatch !== 1'b0) begin errors++; $display("FAIL async_reset got=%b/%h/%b exp=0/00000/0", bus.dma_addr_en, bus.dma_addr, bus.err_nolatch); end
    #1 reset = 1'b0;
    bus.aen = 0; bus.dack = 4'hF;
    tick();
    bus.cs_page = 0; bus.ior_n = 0; bus.addr = 4'h3; sb.push_back(32'h00); tick(); sb_pop(exp);
    checks++; if (bus.cpu_dout_en !== 1'b1 || bus.cpu_dout !== exp[7:0]) begin errors++; $display("FAIL page_reset got=%b/%h exp=1/%h", bus.cpu_dout_en, bus.cpu_dout, exp[7:0]); end
    bus.ior_n = 1; bus.cs_page = 1; tick();
  endtask

  initial begin
    test_reset();
    test_cpu_rw();
    test_dma_xfer();
    test_nolatch_err();
    test_aen_blocks_write();
    test_back_to_back();
    test_reset_mid_xfer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
